gcd_share_arbiter: RTL and testbench

//  Round-robin arbiter that shares one gcd_machine engine among NREQ requesters.

---
 rtl/gcd_share_arbiter.sv | 158 +++++++++++++++
 tb/tb_gcd_share_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_share_arbiter.sv
// Round-robin arbiter sharing one gcd engine among NREQ requesters.
// Optional watchdog: define GCD_ARB_TIMEOUT_EN.
module gcd_share_arbiter #(
  parameter int NREQ           = 4,
  parameter int W              = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] a_flat,
  input  logic [NREQ*W-1:0] b_flat,
  output logic [NREQ-1:0] ack,
  output logic [NREQ-1:0] rsp_valid,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_err,
  output logic            busy,
  output logic            gcd_go,
  output logic [W-1:0]    gcd_in1,
  output logic [W-1:0]    gcd_in2,
  input  logic [W-1:0]    gcd_out,
  input  logic            gcd_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RESP
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr;
  logic [IW-1:0]   idx;
  logic            found;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   nxt_rr;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [NREQ-1:0] gnt_oh;
  logic [NREQ-1:0] idx_oh;
  logic            tmo;

  // Scan req from the rr pointer upward with wrap; first hit wins.
  always_comb begin
    int j;
    found  = 1'b0;
    gidx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        gidx  = IW'(j);
      end
    end
    nxt_rr = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
    a_sel  = a_flat[gidx*W +: W];
    b_sel  = b_flat[gidx*W +: W];
    gnt_oh = '0;
    gnt_oh[gidx] = 1'b1;
    idx_oh = '0;
    idx_oh[idx] = 1'b1;
  end

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  assign tmo = ((state == LAUNCH) || (state == BUSY)) &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent waiting on the engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (((state == LAUNCH) || (state == BUSY)) && !tmo) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end
`else
  // Watchdog compiled out: engine waits are unbounded.
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif

  // Main sequencer; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= '0;
      idx       <= '0;
      ack       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      gcd_go    <= 1'b0;
      gcd_in1   <= '0;
      gcd_in2   <= '0;
    end else begin
      ack       <= '0;
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (found && gcd_done) begin
            idx     <= gidx;
            rr      <= nxt_rr;
            gcd_in1 <= a_sel;
            gcd_in2 <= b_sel;
            ack     <= gnt_oh;
            busy    <= 1'b1;
            if ((a_sel == '0) || (b_sel == '0)) begin
              rsp_data <= a_sel | b_sel;
              rsp_err  <= 1'b0;
              state    <= RESP;
            end else begin
              gcd_go <= 1'b1;
              state  <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (tmo) begin
            gcd_go   <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= RESP;
          end else if (!gcd_done) begin
            gcd_go <= 1'b0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (gcd_done) begin
            rsp_data <= gcd_out;
            rsp_err  <= 1'b0;
            state    <= RESP;
          end else if (tmo) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= idx_oh;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_share_arbiter.sv
// Scoreboard bench for gcd_share_arbiter with a behavioural engine.
// Watchdog case runs only with GCD_ARB_TIMEOUT_EN.
module tb_gcd_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] a_flat;
  logic [NREQ*W-1:0] b_flat;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] rsp_valid;
  logic [W-1:0]    rsp_data;
  logic            rsp_err;
  logic            busy;
  logic            gcd_go;
  logic [W-1:0]    gcd_in1;
  logic [W-1:0]    gcd_in2;
  logic [W-1:0]    gcd_out;
  logic            gcd_done;

  gcd_share_arbiter #(
    .NREQ(NREQ), .W(W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a_flat(a_flat), .b_flat(b_flat),
    .ack(ack), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .gcd_go(gcd_go),
    .gcd_in1(gcd_in1), .gcd_in2(gcd_in2),
    .gcd_out(gcd_out), .gcd_done(gcd_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       idx;
    logic [7:0] data;
    logic     err;
    bit       byp;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int rsp_cyc = 0;
  int go_cyc = 0;
  int go_cnt = 0;
  logic go_q = 1'b0;

  // behavioural engine
  logic hang = 1'b0;
  int   eng_lat = 3;
  int   eng_cnt;
  logic eng_run;
  logic [7:0] eng_res;

  function automatic logic [7:0] gcd_f(logic [7:0] x, logic [7:0] y);
    logic [7:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcd_done <= 1'b1;
      gcd_out  <= '0;
      eng_run  <= 1'b0;
      eng_cnt  <= 0;
      eng_res  <= '0;
    end else if (eng_run) begin
      if (eng_cnt == 0) begin
        gcd_done <= 1'b1;
        gcd_out  <= eng_res;
        eng_run  <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end else if (gcd_go && gcd_done) begin
      gcd_done <= 1'b0;
      if (!hang) begin
        eng_res <= gcd_f(gcd_in1, gcd_in2);
        eng_cnt <= eng_lat;
        eng_run <= 1'b1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every response
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (|ack) begin
        ack_cyc = cyc;
        chk("ack_rsp_excl", 32'(rsp_valid), 0);
      end
      if (gcd_go && !go_q) begin
        go_cnt++;
        go_cyc = cyc;
      end
      go_q = gcd_go;
      if (|rsp_valid) begin
        rsp_cyc = cyc;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got %0h expected none",
                   rsp_valid);
        end else begin
          e = q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("busy_at_rsp", 32'(busy), 0);
          if (e.byp)
            chk("byp_latency", cyc - ack_cyc, 1);
          else
            chk("lat_ge3", 32'(cyc - ack_cyc >= 3), 1);
        end
      end
    end else begin
      go_q = 1'b0;
    end
  end

  task automatic set_ops(int i, logic [7:0] a, logic [7:0] b);
    a_flat[i*W +: W] = a;
    b_flat[i*W +: W] = b;
  endtask

  task automatic push(int i, logic [7:0] d, logic er, bit byp);
    exp_t e;
    e.idx = i; e.data = d; e.err = er; e.byp = byp;
    q.push_back(e);
  endtask

  task automatic wait_ack(int i);
    bit ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ack[i]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk($sformatf("ack_timeout_%0d", i), 0, 1);
  endtask

  task automatic issue(int i, logic [7:0] a, logic [7:0] b,
                       logic [7:0] d, logic er);
    set_ops(i, a, b);
    push(i, d, er, (a == 0) || (b == 0));
    req[i] = 1'b1;
    wait_ack(i);
    req[i] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic drop_after(int i, int n);
    for (int k = 0; k < n; k++) wait_ack(i);
    req[i] = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_gcd_go"}, 32'(gcd_go), 0);
    chk({tag, "_gcd_in1"}, 32'(gcd_in1), 0);
    chk({tag, "_gcd_in2"}, 32'(gcd_in2), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int g0;
    bit ok;
    rst_n  = 1'b0;
    req    = '0;
    a_flat = '0;
    b_flat = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // T3: 0 and 3 together, each re-requesting once
    set_ops(0, 8'd48, 8'd36);
    set_ops(3, 8'd21, 8'd49);
    push(0, 8'd12, 1'b0, 0);
    push(3, 8'd7, 1'b0, 0);
    push(0, 8'd12, 1'b0, 0);
    push(3, 8'd7, 1'b0, 0);
    req[0] = 1'b1;
    req[3] = 1'b1;
    fork
      drop_after(0, 2);
      drop_after(3, 2);
    join
    drain();

    // T1
    g0 = go_cnt;
    issue(0, 8'd20, 8'd15, 8'd5, 1'b0);
    drain();
    chk("t1_go_bursts", go_cnt - g0, 1);

    // T2
    issue(2, 8'd35, 8'd14, 8'd7, 1'b0);
    drain();

    // T4: zero bypass
    g0 = go_cnt;
    issue(1, 8'd0, 8'd0, 8'd0, 1'b0);
    drain();
    issue(1, 8'd0, 8'd9, 8'd9, 1'b0);
    drain();
    chk("t4_no_go", go_cnt - g0, 0);

    // T5: reset while engine busy
    eng_lat = 10;
    set_ops(2, 8'd35, 8'd14);
    req[2] = 1'b1;
    wait_ack(2);
    req[2] = 1'b0;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (busy && !gcd_go) begin
        ok = 1;
        break;
      end
    end
    chk("t5_reach_busy", 32'(ok), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    eng_lat = 3;
    repeat (3) @(negedge clk);
    chk("t5_no_rsp", q.size(), 0);
    issue(0, 8'd12, 8'd18, 8'd6, 1'b0);
    drain();

`ifdef GCD_ARB_TIMEOUT_EN
    // T6: engine hangs, watchdog reports an error
    hang = 1'b1;
    issue(1, 8'd8, 8'd12, 8'd0, 1'b1);
    drain();
    chk("t6_tmo_latency",
        32'((rsp_cyc - go_cyc >= 16) && (rsp_cyc - go_cyc <= 17)), 1);
    chk("t6_idle", 32'(busy), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
